// File: rtl/telemetry_framer.sv
// Periodic telemetry packetiser: every PERIOD cycles emits HEADER, seq, channel bytes (MSB first), XOR checksum.
// First byte is offered the cycle after the tick; bytes hold while fifo_full_i is high, and ticks during a frame are dropped and counted.
module telemetry_framer #(
    parameter int         NUM_CH    = 2,
    parameter int         WIDTH_VAL = 14,
    parameter int         DATA_SIZE = 8,
    parameter int         PERIOD    = 16384,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic [NUM_CH-1:0]           ch_valid_i,
    input  logic [NUM_CH*WIDTH_VAL-1:0] ch_data_i,
    input  logic                        fifo_full_i,
    output logic                        write_o,
    output logic [DATA_SIZE-1:0]        data_o,
    output logic                        busy_o,
    output logic [7:0]                  overrun_cnt_o
);
    localparam int BPC       = (WIDTH_VAL + 7) / 8;
    localparam int FRAME_LEN = 3 + NUM_CH * BPC;
    localparam int CNT_W     = $clog2(PERIOD);
    localparam int IDX_W     = $clog2(FRAME_LEN);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tick;
    logic [IDX_W-1:0]     byte_idx_q;
    logic                 last_byte;
    logic [7:0]           seq_q;
    logic [7:0]           chk_q, chk_d;
    logic [7:0]           overrun_q;
    logic [7:0]           data_mux;
    logic [WIDTH_VAL-1:0] latch_q  [NUM_CH];
    logic [WIDTH_VAL-1:0] shadow_q [NUM_CH];
    logic [WIDTH_VAL-1:0] snap     [NUM_CH];

    // Byte b (0 = most significant) of a value zero-extended to BPC bytes.
    function automatic logic [7:0] val_byte(input logic [WIDTH_VAL-1:0] v, input int b);
        logic [BPC*8-1:0] e;
        e = '0;
        e[WIDTH_VAL-1:0] = v;
        return e[(BPC-1-b)*8 +: 8];
    endfunction

    assign tick      = enable_i && (cnt_q == CNT_W'(PERIOD - 1));
    assign last_byte = (byte_idx_q == IDX_W'(FRAME_LEN - 1));

    always_comb begin
        cnt_d = '0;
        if (enable_i && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A strobe on the tick cycle bypasses the latch so the frame carries the newest sample.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            snap[i] = ch_valid_i[i] ? ch_data_i[i*WIDTH_VAL +: WIDTH_VAL] : latch_q[i];
        end
    end

    always_comb begin
        chk_d = HEADER ^ seq_q;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int b = 0; b < BPC; b++) begin
                chk_d = chk_d ^ val_byte(snap[i], b);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (tick) state_d = SEND;
            SEND: if (write_o && last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == SEND);
        write_o = busy_o && !fifo_full_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            overrun_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (tick && (state_q == SEND) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                latch_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid_i[i]) latch_q[i] <= ch_data_i[i*WIDTH_VAL +: WIDTH_VAL];
                if ((state_q == IDLE) && tick) shadow_q[i] <= snap[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            byte_idx_q <= '0;
            seq_q      <= '0;
            chk_q      <= '0;
        end else if (state_q == IDLE) begin
            if (tick) begin
                byte_idx_q <= '0;
                chk_q      <= chk_d;
            end
        end else if (write_o) begin
            if (last_byte) begin
                byte_idx_q <= '0;
                seq_q      <= seq_q + 8'd1;
            end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        data_mux = chk_q;
        if (byte_idx_q == '0) begin
            data_mux = HEADER;
        end else if (byte_idx_q == IDX_W'(1)) begin
            data_mux = seq_q;
        end
        for (int k = 0; k < NUM_CH * BPC; k++) begin
            if (byte_idx_q == IDX_W'(k + 2)) data_mux = val_byte(shadow_q[k / BPC], k % BPC);
        end
    end

    assign data_o        = busy_o ? data_mux : '0;
    assign overrun_cnt_o = overrun_q;
endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: directed table, frame-level reference model under random stimulus, and overrun saturation.
module tb_telemetry_framer;
    localparam int P  = 64;
    localparam int FL = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, fifo_full, write, busy;
    logic [1:0]  ch_valid;
    logic [27:0] ch_data;
    logic [7:0]  data, ovr;

    logic        reset4, enable4, full4, write4, busy4;
    logic [1:0]  vld4;
    logic [27:0] data4_in;
    logic [7:0]  dat4, ovr4;

    telemetry_framer #(.NUM_CH(2), .WIDTH_VAL(14), .DATA_SIZE(8), .PERIOD(P), .HEADER(8'hA5)) u_dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .ch_valid_i(ch_valid), .ch_data_i(ch_data),
        .fifo_full_i(fifo_full), .write_o(write), .data_o(data), .busy_o(busy), .overrun_cnt_o(ovr)
    );

    telemetry_framer #(.NUM_CH(2), .WIDTH_VAL(14), .DATA_SIZE(8), .PERIOD(4), .HEADER(8'hA5)) u_dut4 (
        .clk_i(clk), .reset_i(reset4), .enable_i(enable4), .ch_valid_i(vld4), .ch_data_i(data4_in),
        .fifo_full_i(full4), .write_o(write4), .data_o(dat4), .busy_o(busy4), .overrun_cnt_o(ovr4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: a queue holds the bytes of the frame still owed to the FIFO.
    logic [13:0] m_lat [2];
    int          m_cnt;
    logic [7:0]  m_seq;
    logic [7:0]  m_q [$];
    int          m_ovr;
    logic [7:0]  got [$];
    int          pos, zseq;

    function automatic void model_reset();
        m_lat[0] = '0; m_lat[1] = '0;
        m_cnt = 0; m_seq = '0; m_ovr = 0;
        m_q.delete();
    endfunction

    function automatic void model_step(input logic en, input logic [1:0] vld,
                                       input logic [13:0] d0, input logic [13:0] d1, input logic full);
        bit          was_busy;
        logic [13:0] v [2];
        logic [7:0]  x;
        was_busy = (m_q.size() != 0);
        if (was_busy && !full) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_seq++;
        end
        if (en && (m_cnt == P - 1)) begin
            if (was_busy) begin
                if (m_ovr < 255) m_ovr++;
            end else begin
                v[0] = vld[0] ? d0 : m_lat[0];
                v[1] = vld[1] ? d1 : m_lat[1];
                m_q.push_back(8'hA5);
                m_q.push_back(m_seq);
                for (int c = 0; c < 2; c++) begin
                    m_q.push_back({2'b00, v[c][13:8]});
                    m_q.push_back(v[c][7:0]);
                end
                x = 8'h00;
                foreach (m_q[i]) x = x ^ m_q[i];
                m_q.push_back(x);
            end
        end
        m_cnt = en ? (m_cnt + 1) % P : 0;
        if (vld[0]) m_lat[0] = d0;
        if (vld[1]) m_lat[1] = d1;
    endfunction

    task automatic check_model(input logic full);
        logic mb;
        mb = (m_q.size() != 0);
        check("busy", busy, mb);
        check("write", write, mb && !full);
        check("data", data, mb ? m_q[0] : 8'h00);
        check("overrun", ovr, m_ovr);
        if (write) begin
            got.push_back(data);
            if (pos == 1 && data == 8'h00) zseq++;
            pos = (pos + 1) % FL;
        end
    endtask

    task automatic cyc(input logic en, input logic [1:0] vld, input logic [13:0] d0,
                       input logic [13:0] d1, input logic full);
        @(negedge clk);
        enable = en; ch_valid = vld; ch_data = {d1, d0}; fifo_full = full;
        #1;
        check_model(full);
        model_step(en, vld, d0, d1, full);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; ch_valid = '0; ch_data = '0; fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        pos = 0;
        got.delete();
    endtask

    typedef struct {
        int reps; logic en; logic [1:0] vld; logic [13:0] d0; logic [13:0] d1; logic full;
        logic wr; logic [7:0] dat; logic busy;
    } vec_t;
    vec_t tbl [$];

    function automatic void add(input int reps, input logic [1:0] vld, input logic [13:0] d0, input logic [13:0] d1,
                                input logic full, input logic wr, input logic [7:0] dat, input logic bsy);
        vec_t v;
        v.reps = reps; v.en = 1'b1; v.vld = vld; v.d0 = d0; v.d1 = d1; v.full = full;
        v.wr = wr; v.dat = dat; v.busy = bsy;
        tbl.push_back(v);
    endfunction

    logic [7:0] f1 [7] = '{8'hA5, 8'h00, 8'h2F, 8'h9A, 8'h01, 8'h23, 8'h32};
    logic [7:0] f2 [7] = '{8'hA5, 8'h01, 8'h2F, 8'h9A, 8'h01, 8'h23, 8'h33};
    logic [7:0] f3 [7] = '{8'hA5, 8'h02, 8'h2F, 8'h9A, 8'h01, 8'h23, 8'h30};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        en_r, full_r;
        logic [1:0]  vr;
        logic [13:0] r0, r1;
        int          burst, e4;

        reset4 = 1'b1; enable4 = 1'b0; full4 = 1'b0; vld4 = '0; data4_in = '0;

        // Overrun counting and saturation with PERIOD=4 and the FIFO stuck full.
        repeat (2) @(posedge clk);
        #1 reset4 = 1'b0;
        check("ovr4_reset", ovr4, 0);
        for (int c = 0; c < 1340; c++) begin
            @(negedge clk);
            enable4 = 1'b1; full4 = 1'b1;
            #1;
            e4 = c / 4 - 1;
            if (e4 < 0) e4 = 0;
            if (e4 > 255) e4 = 255;
            check("ovr4_count", ovr4, e4);
            check("wr4_while_full", write4, 0);
            if (c <= 40) check("busy4", busy4, c >= 4);
        end
        check("ovr4_saturated", ovr4, 255);
        reset4 = 1'b1;

        // Directed table: three frames, the third with a 5-cycle FIFO stall after byte 3.
        do_reset();
        check("reset_write", write, 0);
        check("reset_data", data, 0);
        check("reset_busy", busy, 0);
        check("reset_ovr", ovr, 0);
        add(1, 2'b11, 14'h2F9A, 14'h0123, 0, 0, 8'h00, 0);
        add(63, 2'b00, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) add(1, 2'b00, 0, 0, 0, 1, f1[i], 1);
        add(57, 2'b00, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) add(1, 2'b00, 0, 0, 0, 1, f2[i], 1);
        add(57, 2'b00, 0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) add(1, 2'b00, 0, 0, 0, 1, f3[i], 1);
        add(5, 2'b00, 0, 0, 1, 0, 8'h9A, 1);
        for (int i = 3; i < 7; i++) add(1, 2'b00, 0, 0, 0, 1, f3[i], 1);
        add(1, 2'b00, 0, 0, 0, 0, 8'h00, 0);
        foreach (tbl[t]) begin
            for (int r = 0; r < tbl[t].reps; r++) begin
                cyc(tbl[t].en, tbl[t].vld, tbl[t].d0, tbl[t].d1, tbl[t].full);
                check("tbl_write", write, tbl[t].wr);
                check("tbl_data", data, tbl[t].dat);
                check("tbl_busy", busy, tbl[t].busy);
            end
        end

        // Random traffic against the model, long enough for the sequence number to wrap.
        en_r = 1'b1; burst = 0; zseq = 0;
        for (int i = 0; i < 24000; i++) begin
            if (en_r) begin
                if ($urandom_range(0, 2999) == 0) en_r = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                en_r = 1'b1;
            end
            if (burst > 0) burst--;
            else if ($urandom_range(0, 999) == 0) burst = int'($urandom_range(60, 200));
            full_r = (burst > 0) || ($urandom_range(0, 99) < 15);
            vr = 2'($urandom_range(0, 3));
            r0 = 14'($urandom_range(0, 16383));
            r1 = 14'($urandom_range(0, 16383));
            cyc(en_r, vr, r0, r1, full_r);
        end
        check("seq_wrap_seen", zseq != 0, 1);

        // Reset while byte 4 of a frame is pending.
        for (int i = 0; i < 300 && m_q.size() != FL - 4; i++) cyc(1, 2'b00, 0, 0, 0);
        check("midframe_busy", busy, 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_write", write, 0);
        check("rst_mid_data", data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ovr", ovr, 0);
        @(posedge clk);
        #1;
        check("rst_hold_write", write, 0);
        do_reset();
        for (int i = 0; i < 75; i++) cyc(1, 2'b00, 0, 0, 0);
        check("post_rst_len", got.size(), 7);
        if (got.size() >= 2) begin
            check("post_rst_hdr", got[0], 8'hA5);
            check("post_rst_seq", got[1], 8'h00);
        end

        // Bypass on the tick cycle, then drop enable mid-frame.
        got.delete();
        for (int i = 0; i < 300 && (m_cnt != P - 1 || m_q.size() != 0); i++) cyc(1, 2'b00, 0, 0, 0);
        cyc(1, 2'b01, 14'h1555, 14'h0000, 0);
        cyc(1, 2'b00, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 2'b00, 0, 0, 0);
        check("bypass_len", got.size(), 7);
        if (got.size() >= 4) begin
            check("bypass_seq", got[1], 8'h01);
            check("bypass_hi", got[2], 8'h15);
            check("bypass_lo", got[3], 8'h55);
        end
        check("disabled_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/telemetry_framer.md
# telemetry_framer

Parametrised periodic telemetry packetiser that sits between the sensor/measurement logic and the UART transmit FIFO. It latches the most recent sample of each of NUM_CH channels, and every PERIOD clock cycles serialises one framed packet (header, sequence number, channel payloads, XOR checksum) into the FIFO. Writes stall while the FIFO is full. This block replaces the fixed single-channel, fixed-interval push logic.

## Interface
- NUM_CH, 2, number of telemetry channels (1..8)
- WIDTH_VAL, 14, bits per channel value (1..32)
- DATA_SIZE, 8, FIFO byte width (fixed at 8; other values are unsupported)
- PERIOD, 16384, frame interval in clk cycles (≥ 2)
- HEADER, 8'hA5, frame start byte
- BPC (derived), ceil(WIDTH_VAL/8), bytes per channel
- FRAME_LEN (derived), 3 + NUM_CH*BPC, bytes per frame

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = periodic ticks run; 0 = tick counter held at 0
- ch_valid  in  NUM_CH  per-channel sample strobe
- ch_data  in  NUM_CH*WIDTH_VAL  channel values; channel i occupies bits [i*WIDTH_VAL +: WIDTH_VAL]
- fifo_full  in  1  TX FIFO full flag
- write  out  1  FIFO write strobe
- data  out  8  FIFO write data
- busy  out  1  frame in progress (state SEND)
- overrun_cnt  out  8  saturating count of dropped ticks

## Operation
- Channel latches: on each clk where ch_valid[i]=1, latch[i] <= ch_data[i]. Reset value is 0.
- Tick counter: while enable=1 it counts 0..PERIOD-1 and wraps. tick=1 when the count equals PERIOD-1. While enable=0 the count is forced to 0 and no ticks occur.
- FSM has two states:
  - IDLE → SEND on tick. On the same edge: snapshot all channels into a shadow register, byte_idx <= 0, and compute the running checksum. If ch_valid[i]=1 on the tick cycle, the shadow takes ch_data[i] directly (bypass).
  - SEND → IDLE when the byte at byte_idx = FRAME_LEN-1 is accepted. On that edge seq increments (8-bit, wraps 255→0).
- Frame byte order:
  - HEADER
  - seq
  - for ch 0..NUM_CH-1: BPC bytes, MSB first, value zero-extended to BPC*8 bits
  - checksum = XOR of all preceding bytes in the frame
- Write handshake: write = busy & ~fifo_full (combinational from fifo_full). data is a mux of the shadow registers by byte_idx and is stable for the whole time a byte is pending. byte_idx advances only on an accepted byte (write=1).
- Overrun: a tick that arrives while busy=1 is dropped and overrun_cnt increments, saturating at 255. No other effect. The frame in progress is unaffected.
- Dropping enable mid-frame does not abort the frame: it completes, and no new tick occurs until enable returns.
- Reset mid-frame: the frame is abandoned immediately. All state returns to reset values and no partial bytes are written after reset.

## Timing
- Reset values: write=0, data=0, busy=0, overrun_cnt=0, seq=0, byte_idx=0, tick counter=0, latches/shadow=0.
- A tick at cycle T gives busy=1 and first write possible at T+1.
- With fifo_full=0 throughout, bytes are written on consecutive cycles T+1..T+FRAME_LEN, and busy=0 at T+FRAME_LEN+1.
- Each cycle of fifo_full=1 during SEND delays all remaining bytes by one cycle. No byte is skipped or duplicated.
- First tick after reset or after enable rises occurs PERIOD cycles later; tick spacing is exactly PERIOD cycles.
- A tick on the same cycle as the final byte being accepted counts as an overrun (the FSM is still in SEND).

## Test plan
- NUM_CH=2, WIDTH_VAL=14, PERIOD=64, fifo_full=0. Latch ch0=0x2F9A and ch1=0x0123, then wait for the first tick → write strobes A5, 00, 2F, 9A, 01, 23, 32 on 7 consecutive cycles, then busy=0.
- Second frame with the same values → seq byte 01, checksum 0x33. Run 256 frames → seq wraps back to 00.
- Hold fifo_full=1 for 5 cycles after the 3rd byte → remaining bytes are delayed by 5 cycles, the byte sequence is identical, and write=0 while full.
- PERIOD=4 with fifo_full stuck at 1 for 40 cycles → overrun_cnt increments once per tick. Over 300 dropped ticks → overrun_cnt saturates at 255.
- Assert reset at byte 4 of a frame → all outputs return to reset values within the reset cycle. The next frame starts with A5, 00 and contains no leftover bytes.
- ch_valid[0] pulsed with 0x1555 on the tick cycle → that frame carries 15, 55 for ch0 (bypass). Deassert enable mid-frame → the frame completes and no further ticks occur.
